perm_round_sequencer: RTL and testbench

Sequences the bit-serial permutation datapath for the encryption controller. It counts slice cycles and rounds, and generates the per-round constant and phase enables for the datapath. It returns the count_done and iteration_done handshake that the controller waits on before each phase transition. It sits between the top-level encryption FSM (which drives load_n/iteration) and the permutation datapath (which consumes phase enables, bit_idx and round_const).

---
 rtl/perm_round_sequencer_if.sv | 32 +++
 rtl/perm_round_sequencer.sv | 127 ++++++++++++
 tb/tb_perm_round_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/perm_round_sequencer_if.sv
// Handshake bundle between the encryption controller (master) and the
// permutation round sequencer (slave).
interface perm_round_sequencer_if #(
    parameter int SLICE_BITS = 64
) ();
    localparam int BW = $clog2(SLICE_BITS);

    logic          load_n;
    logic [3:0]    iteration;
    logic          stall;
    logic          pc_en;
    logic          ps_en;
    logic          pl_en;
    logic [BW-1:0] bit_idx;
    logic [3:0]    round_idx;
    logic [7:0]    round_const;
    logic          count_done;
    logic          iteration_done;
    logic          busy;

    modport master (
        output load_n, iteration, stall,
        input  pc_en, ps_en, pl_en, bit_idx, round_idx, round_const,
               count_done, iteration_done, busy
    );

    modport slave (
        input  load_n, iteration, stall,
        output pc_en, ps_en, pl_en, bit_idx, round_idx, round_const,
               count_done, iteration_done, busy
    );
endinterface

// File: rtl/perm_round_sequencer.sv
// Round/slice sequencer for the bit-serial permutation datapath: walks
// ADD_C -> SBOX -> LIN per round and publishes phase enables and done flags.
module perm_round_sequencer #(
    parameter int SLICE_BITS = 64,
    parameter int MAX_ITER   = 11
) (
    input  logic                      clk,
    input  logic                      rst,
    perm_round_sequencer_if.slave     bus
);
    localparam int           BW         = $clog2(SLICE_BITS);
    localparam logic [BW-1:0] LAST_BIT  = BW'(SLICE_BITS - 1);
    localparam logic [3:0]   MAX_ITER_L = 4'(MAX_ITER);

    typedef enum logic [2:0] {IDLE, ADD_C, SBOX, LIN, DONE} state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] bit_idx_q, bit_idx_d;
    logic [3:0]    round_idx_q, round_idx_d;
    logic [3:0]    iteration_q, iteration_d;

    logic          pc_en_q, pc_en_d;
    logic          ps_en_q, ps_en_d;
    logic          pl_en_q, pl_en_d;
    logic          busy_q, busy_d;
    logic          count_done_q, count_done_d;
    logic          iter_done_q, iter_done_d;
    logic [7:0]    round_const_q, round_const_d;
    logic [3:0]    rc_idx;

    // Next-state logic; a restart request wins over stall in every state.
    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        round_idx_d = round_idx_q;
        iteration_d = iteration_q;
        if (!bus.load_n) begin
            iteration_d = (bus.iteration > MAX_ITER_L) ? MAX_ITER_L : bus.iteration;
            bit_idx_d   = '0;
            round_idx_d = '0;
            state_d     = ADD_C;
        end else if (!bus.stall) begin
            unique case (state_q)
                ADD_C: state_d = SBOX;
                SBOX: begin
                    if (bit_idx_q == LAST_BIT) begin
                        bit_idx_d = '0;
                        state_d   = LIN;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
                LIN: begin
                    if (bit_idx_q == LAST_BIT) begin
                        bit_idx_d = '0;
                        if (round_idx_q == iteration_q) begin
                            state_d = DONE;
                        end else begin
                            round_idx_d = round_idx_q + 4'd1;
                            state_d     = ADD_C;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Outputs are decoded from the next state so the registered copies line
    // up with the state they describe, without a cycle of lag.
    always_comb begin
        busy_d       = (state_d == ADD_C) || (state_d == SBOX) || (state_d == LIN);
        pc_en_d      = (state_d == ADD_C);
        ps_en_d      = (state_d == SBOX);
        pl_en_d      = (state_d == LIN);
        count_done_d = ((state_d == LIN) && (bit_idx_d == LAST_BIT)) || (state_d == DONE);
        iter_done_d  = busy_d ? (round_idx_d == iteration_d) : (state_d == DONE);
        rc_idx       = (MAX_ITER_L - iteration_d) + round_idx_d;
        if (busy_d) begin
            round_const_d = {4'hF - rc_idx, rc_idx};
        end else if (state_d == DONE) begin
            round_const_d = round_const_q;
        end else begin
            round_const_d = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            bit_idx_q     <= '0;
            round_idx_q   <= '0;
            iteration_q   <= '0;
            pc_en_q       <= 1'b0;
            ps_en_q       <= 1'b0;
            pl_en_q       <= 1'b0;
            busy_q        <= 1'b0;
            count_done_q  <= 1'b0;
            iter_done_q   <= 1'b0;
            round_const_q <= 8'h00;
        end else begin
            state_q       <= state_d;
            bit_idx_q     <= bit_idx_d;
            round_idx_q   <= round_idx_d;
            iteration_q   <= iteration_d;
            pc_en_q       <= pc_en_d;
            ps_en_q       <= ps_en_d;
            pl_en_q       <= pl_en_d;
            busy_q        <= busy_d;
            count_done_q  <= count_done_d;
            iter_done_q   <= iter_done_d;
            round_const_q <= round_const_d;
        end
    end

    assign bus.pc_en          = pc_en_q;
    assign bus.ps_en          = ps_en_q;
    assign bus.pl_en          = pl_en_q;
    assign bus.busy           = busy_q;
    assign bus.bit_idx        = bit_idx_q;
    assign bus.round_idx      = round_idx_q;
    assign bus.round_const    = round_const_q;
    assign bus.count_done     = count_done_q;
    assign bus.iteration_done = iter_done_q;
endmodule

// File: tb/tb_perm_round_sequencer.sv
// Scoreboard bench for perm_round_sequencer: round constants are queued at
// load time and popped on every ADD_C cycle; done latency and pulses checked.
module tb_perm_round_sequencer;
    localparam int SLICE_BITS = 64;
    localparam int MAX_ITER   = 11;
    localparam int ROUND_LEN  = 1 + 2 * SLICE_BITS;

    logic clk = 1'b0;
    logic rst = 1'b0;

    perm_round_sequencer_if #(.SLICE_BITS(SLICE_BITS)) bus ();

    perm_round_sequencer #(
        .SLICE_BITS(SLICE_BITS),
        .MAX_ITER  (MAX_ITER)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] rcQ[$];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulses load_n for one cycle and queues the constants the run should produce.
    task automatic applyStimulus(input logic [3:0] iter);
        int eff;
        logic [3:0] rc;
        eff = (iter > MAX_ITER) ? MAX_ITER : int'(iter);
        rcQ.delete();
        for (int r = 0; r <= eff; r++) begin
            rc = 4'(MAX_ITER - eff + r);
            rcQ.push_back({4'hF - rc, rc});
        end
        bus.iteration = iter;
        bus.load_n    = 1'b0;
        @(negedge clk);
        bus.load_n    = 1'b1;
        bus.iteration = 4'h0;
    endtask

    // Entered at the first negedge after the load edge; returns at the done cycle.
    task automatic runToDone(input int expLat, input int expPulses, input int stallAt);
        int cyc = 1;
        int pulses = 0;
        int expRound = 0;
        bit done = 1'b0;
        logic [5:0] frozenBit = '0;
        while (!done && cyc <= 5000) begin
            if (bus.pc_en) begin
                if (rcQ.size() == 0) checkOutput("sbUnderflow", 32'd1, 32'd0);
                else checkOutput("roundConst", 32'(bus.round_const), 32'(rcQ.pop_front()));
                checkOutput("roundIdx", 32'(bus.round_idx), 32'(expRound));
                expRound++;
            end
            if (bus.count_done && !bus.iteration_done) pulses++;
            if (bus.count_done && bus.iteration_done) begin
                done = 1'b1;
                checkOutput("latency", 32'(cyc), 32'(expLat));
                checkOutput("pulses", 32'(pulses), 32'(expPulses));
                checkOutput("sbEmpty", 32'(rcQ.size()), 32'd0);
            end else begin
                if (stallAt > 0 && cyc == stallAt) begin
                    frozenBit = bus.bit_idx;
                    bus.stall = 1'b1;
                end
                if (stallAt > 0 && cyc > stallAt && cyc <= stallAt + 10) begin
                    checkOutput("stallBit", 32'(bus.bit_idx), 32'(frozenBit));
                    checkOutput("stallRound", 32'(bus.round_idx), 32'd2);
                    checkOutput("stallPs", 32'({bus.pc_en, bus.ps_en, bus.pl_en}), 32'b010);
                end
                if (stallAt > 0 && cyc == stallAt + 10) bus.stall = 1'b0;
                @(negedge clk);
                cyc++;
            end
        end
        if (!done) checkOutput("doneTimeout", 32'd0, 32'd1);
    endtask

    initial begin
        bus.load_n    = 1'b1;
        bus.iteration = 4'h0;
        bus.stall     = 1'b0;
        #12;
        checkOutput("resetOuts", 32'({bus.busy, bus.pc_en, bus.ps_en, bus.pl_en, bus.count_done,
                    bus.iteration_done, bus.bit_idx, bus.round_idx, bus.round_const}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idleBusy", 32'(bus.busy), 32'd0);

        $display("[TB] full 12-round run");
        applyStimulus(4'd11);
        runToDone(12 * ROUND_LEN, 11, -1);
        @(negedge clk);
        checkOutput("doneBusy", 32'(bus.busy), 32'd0);
        checkOutput("doneFlags", 32'({bus.count_done, bus.iteration_done}), 32'b11);
        checkOutput("doneEnables", 32'({bus.pc_en, bus.ps_en, bus.pl_en}), 32'd0);
        checkOutput("doneConst", 32'(bus.round_const), 32'h4B);

        $display("[TB] 6-round run");
        applyStimulus(4'd5);
        runToDone(6 * ROUND_LEN, 5, -1);

        $display("[TB] restart at done cycle");
        applyStimulus(4'd1);
        runToDone(2 * ROUND_LEN, 1, -1);
        applyStimulus(4'd11);
        checkOutput("restartDone", 32'({bus.count_done, bus.iteration_done}), 32'd0);
        checkOutput("restartPc", 32'(bus.pc_en), 32'd1);
        runToDone(12 * ROUND_LEN, 11, -1);

        $display("[TB] stall in round 2 SBOX");
        applyStimulus(4'd11);
        runToDone(12 * ROUND_LEN + 10, 11, 2 * ROUND_LEN + 1 + 20);

        $display("[TB] clamped iteration");
        applyStimulus(4'd14);
        runToDone(12 * ROUND_LEN, 11, -1);

        $display("[TB] reset mid LIN of round 3");
        applyStimulus(4'd11);
        repeat (479) @(negedge clk);
        checkOutput("preResetPhase", 32'({bus.pl_en, bus.round_idx}), 32'({1'b1, 4'd3}));
        #2 rst = 1'b0;
        #1;
        checkOutput("asyncReset", 32'({bus.busy, bus.pc_en, bus.ps_en, bus.pl_en, bus.count_done,
                    bus.iteration_done, bus.bit_idx, bus.round_idx, bus.round_const}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("staysIdle", 32'({bus.busy, bus.count_done, bus.round_const}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
